wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Shares the register-file write port (A3/WD3/WE) between two writeback requesters:
//  ALU (req 0) and load/store unit (req 1). Round-robin arbitration, one registered write per cycle.
//  Keeps a 32-entry busy scoreboard (set at issue, cleared at write) and raises stall for decode
//  when a source register (A1/A2) has a write still pending.
//  Sits between the execute/memory stages and the register file.
// PARAMETERS
//  XLEN     32  data width of WD3 and requester data
//  NREG     32  scoreboard entries (fixed to 5-bit register index)
// PORTS
//  CLK         in   1     clock, rising edge
//  reset_n     in   1     asynchronous reset, active-low
//  alu_valid   in   1     ALU writeback request
//  alu_rd      in   5     ALU destination register
//  alu_data    in   XLEN  ALU result
//  alu_ready   out  1     ALU request accepted this cycle
//  lsu_valid   in   1     LSU writeback request
//  lsu_rd      in   5     LSU destination register
//  lsu_data    in   XLEN  load data
//  lsu_ready   out  1     LSU request accepted this cycle
//  issue_valid in   1     decode issues an instruction that writes issue_rd
//  issue_rd    in   5     destination of issued instruction
//  flush       in   1     clear all busy bits (pipeline flush)
//  A1, A2      in   5     decode source registers to check
//  stall       out  1     A1 or A2 busy (x0 never busy)
//  A3          out  5     register-file write address
//  WD3         out  XLEN  register-file write data
//  WE          out  1     register-file write enable
// BEHAVIOUR
//  - Reset (reset_n=0, async): WE=0, A3=0, WD3=0, busy[31:0]=0, last_grant=1 (so ALU wins first).
//    stall and *_ready are combinational; during reset stall=0, *_ready=0.
//  - Arbitration (combinational): one valid -> that one granted. Both valid -> the requester NOT
//    in last_grant wins. last_grant updates only on a grant. <=1 ready high per cycle; ready=grant.
//  - Accepted request registered: next cycle WE=1, A3=rd, WD3=data. No grant -> WE=0, A3/WD3 hold.
//    Latency request->WE: exactly 1 cycle. Throughput: one write per cycle, no bubbles.
//  - rd==0 request: accepted (ready=1, counts for round-robin) but WE stays 0 next cycle.
//  - Scoreboard: issue_valid && issue_rd!=0 sets busy[issue_rd] at clock edge.
//    WE=1 clears busy[A3] at clock edge. Same-register set and clear in same cycle: set wins.
//    flush clears every busy bit; flush with issue_valid same cycle: issue set still applies.
//    Flush does not cancel the registered write in flight (it still reaches the register file).
//  - stall = (A1!=0 && busy[A1]) || (A2!=0 && busy[A2]).
//  - Requesters must hold valid/rd/data stable until ready; dropping valid before ready is illegal.
// CONFIGURATION
//  WB_FORWARD_EN defined: stall ignores a register being written this cycle (WE=1 && A3==Ax),
//    because the register file writes at this edge and decode reads after it; busy bits unchanged.
//  WB_FORWARD_EN undefined: stall uses busy bits only (one extra stall cycle on that write).
// TESTING
//  1 reset_n=0 mid-write -> WE=0, A3=0, WD3=0, stall=0 immediately; busy all 0 after release.
//  2 alu_valid only, rd=5, data=32'hDEAD_BEEF -> alu_ready=1; next cycle WE=1, A3=5, WD3=DEADBEEF.
//  3 both valid 4 cycles -> grants ALU,LSU,ALU,LSU; WE high 4 consecutive cycles, matching data.
//  4 issue rd=7, A1=7 -> stall=1 until write to x7; WE=1/A3=7 cycle: stall=0 only with WB_FORWARD_EN;
//    cycle after: stall=0 both builds.
//  5 lsu rd=0 -> lsu_ready=1, WE=0 next cycle; issue rd=0 then A2=0 -> stall=0.
//  6 issue rd=3 in same cycle WE=1/A3=3 -> busy[3]=1 after; flush -> busy all 0, stall=0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter (ALU vs LSU) driving the register-file write port, plus a
// busy scoreboard that stalls decode. Optional macro WB_FORWARD_EN: hide the write landing this cycle.
module wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            CLK,
    input  logic            reset_n,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic            flush,
    input  logic [4:0]      A1,
    input  logic [4:0]      A2,
    output logic            stall,
    output logic [4:0]      A3,
    output logic [XLEN-1:0] WD3,
    output logic            WE
);

`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic            last_grant;   // 0 = ALU won last, 1 = LSU won last
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            alu_win;
    logic            lsu_win;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    function automatic logic src_busy(input logic [4:0] a, input logic [NREG-1:0] b,
                                      input logic we, input logic [4:0] wa);
        logic hit;
        hit = (a != 5'd0) && b[a];
        if (FWD && we && (wa == a))
            hit = 1'b0;
        return hit;
    endfunction

    // Stage p0: combinational grant and scoreboard next-state
    always_comb begin
        alu_win  = alu_valid && (!lsu_valid || last_grant);
        lsu_win  = lsu_valid && !alu_win;
        sel_rd   = lsu_win ? lsu_rd   : alu_rd;
        sel_data = lsu_win ? lsu_data : alu_data;
    end

    always_comb begin
        busy_nxt = busy;
        if (flush)
            busy_nxt = '0;
        else if (WE)
            busy_nxt[A3] = 1'b0;
        // An issue in the same cycle as a clear or flush is a newer producer, so it wins.
        if (issue_valid && (issue_rd != 5'd0))
            busy_nxt[issue_rd] = 1'b1;
    end

    assign alu_ready = reset_n && alu_win;
    assign lsu_ready = reset_n && lsu_win;
    assign stall     = src_busy(A1, busy, WE, A3) || src_busy(A2, busy, WE, A3);

    // Stage p1: registered write port and arbitration state
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            WE         <= 1'b0;
            A3         <= 5'd0;
            WD3        <= '0;
            last_grant <= 1'b1;
            busy       <= '0;
        end else begin
            busy <= busy_nxt;
            if (alu_win || lsu_win) begin
                last_grant <= lsu_win;
                WE         <= (sel_rd != 5'd0);
                if (sel_rd != 5'd0) begin
                    A3  <= sel_rd;
                    WD3 <= sel_data;
                end
            end else begin
                WE <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed table-driven bench for wb_arbiter: arbitration order, write latency, scoreboard, reset.
module tb_wb_arbiter;

`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        CLK;
    logic        reset_n;
    logic        alu_valid, lsu_valid, issue_valid, flush;
    logic [4:0]  alu_rd, lsu_rd, issue_rd, A1, A2, A3;
    logic [31:0] alu_data, lsu_data, WD3;
    logic        alu_ready, lsu_ready, stall, WE;

    int errors = 0;
    int checks = 0;

    wb_arbiter #(.XLEN(32), .NREG(32)) dut (
        .CLK(CLK), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
        .A1(A1), .A2(A2), .stall(stall), .A3(A3), .WD3(WD3), .WE(WE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        av; logic [4:0] ard; logic [31:0] adat;
        logic        lv; logic [4:0] lrd; logic [31:0] ldat;
        logic        iv; logic [4:0] ird; logic fl;
        logic [4:0]  a1; logic [4:0] a2;
        logic        ar; logic lr; logic st; logic stf; logic we;
        logic [4:0]  a3; logic [31:0] wd;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        issue_valid = 0; issue_rd = 0; flush = 0; A1 = 0; A2 = 0;
    endtask

    initial begin
        vec_t v;
        // av ard adat | lv lrd ldat | iv ird fl | a1 a2 || ar lr st stf we a3 wd
        vq.push_back('{0,0,0,          0,0,0,      0,0,0, 0,0, 0,0,0,0,0,0,0});
        vq.push_back('{1,1,'h11,       1,2,'h22,   0,0,0, 0,0, 1,0,0,0,0,0,0});
        vq.push_back('{1,3,'h33,       1,2,'h22,   0,0,0, 0,0, 0,1,0,0,1,1,'h11});
        vq.push_back('{1,3,'h33,       1,4,'h44,   0,0,0, 0,0, 1,0,0,0,1,2,'h22});
        vq.push_back('{1,5,'h55,       1,4,'h44,   0,0,0, 0,0, 0,1,0,0,1,3,'h33});
        vq.push_back('{1,5,'h55,       0,0,0,      0,0,0, 0,0, 1,0,0,0,1,4,'h44});
        vq.push_back('{0,0,0,          0,0,0,      0,0,0, 0,0, 0,0,0,0,1,5,'h55});
        vq.push_back('{1,5,'hDEADBEEF, 0,0,0,      0,0,0, 0,0, 1,0,0,0,0,5,'h55});
        vq.push_back('{0,0,0,          0,0,0,      0,0,0, 0,0, 0,0,0,0,1,5,'hDEADBEEF});
        vq.push_back('{0,0,0,          0,0,0,      1,7,0, 7,0, 0,0,0,0,0,5,'hDEADBEEF});
        vq.push_back('{0,0,0,          0,0,0,      0,0,0, 7,0, 0,0,1,1,0,5,'hDEADBEEF});
        vq.push_back('{0,0,0,          1,7,'h77,   0,0,0, 7,0, 0,1,1,1,0,5,'hDEADBEEF});
        vq.push_back('{0,0,0,          0,0,0,      0,0,0, 7,0, 0,0,1,0,1,7,'h77});
        vq.push_back('{0,0,0,          0,0,0,      0,0,0, 7,0, 0,0,0,0,0,7,'h77});
        vq.push_back('{0,0,0,          1,0,'h99,   0,0,0, 0,0, 0,1,0,0,0,7,'h77});
        vq.push_back('{0,0,0,          0,0,0,      1,0,0, 0,0, 0,0,0,0,0,7,'h77});
        vq.push_back('{0,0,0,          0,0,0,      0,0,0, 0,0, 0,0,0,0,0,7,'h77});
        vq.push_back('{1,8,'h88,       1,9,'h99,   0,0,0, 0,0, 1,0,0,0,0,7,'h77});
        vq.push_back('{0,0,0,          1,9,'h99,   0,0,0, 0,0, 0,1,0,0,1,8,'h88});
        vq.push_back('{0,0,0,          0,0,0,      0,0,0, 0,0, 0,0,0,0,1,9,'h99});
        vq.push_back('{1,3,'h333,      0,0,0,      0,0,0, 0,0, 1,0,0,0,0,9,'h99});
        vq.push_back('{0,0,0,          0,0,0,      1,3,0, 3,0, 0,0,0,0,1,3,'h333});
        vq.push_back('{0,0,0,          0,0,0,      0,0,0, 3,0, 0,0,1,1,0,3,'h333});
        vq.push_back('{0,0,0,          0,0,0,      0,0,1, 3,0, 0,0,1,1,0,3,'h333});
        vq.push_back('{0,0,0,          0,0,0,      0,0,0, 3,0, 0,0,0,0,0,3,'h333});
        vq.push_back('{0,0,0,          0,0,0,      1,6,1, 0,6, 0,0,0,0,0,3,'h333});
        vq.push_back('{0,0,0,          0,0,0,      0,0,0, 0,6, 0,0,1,1,0,3,'h333});
        vq.push_back('{0,0,0,          0,0,0,      0,0,1, 0,6, 0,0,1,1,0,3,'h333});
        vq.push_back('{0,0,0,          0,0,0,      0,0,0, 0,6, 0,0,0,0,0,3,'h333});
        vq.push_back('{1,10,'hA0,      0,0,0,      0,0,0, 0,0, 1,0,0,0,0,3,'h333});
        vq.push_back('{0,0,0,          0,0,0,      0,0,1, 0,0, 0,0,0,0,1,10,'hA0});
        vq.push_back('{0,0,0,          0,0,0,      0,0,0, 0,0, 0,0,0,0,0,10,'hA0});

        // Reset state, with requests pending so ready gating is visible
        idle_inputs();
        reset_n = 0;
        alu_valid = 1; lsu_valid = 1; alu_rd = 1; lsu_rd = 2; A1 = 4;
        #2;
        check("rst WE", WE, 0);
        check("rst A3", A3, 0);
        check("rst WD3", WD3, 0);
        check("rst stall", stall, 0);
        check("rst alu_ready", alu_ready, 0);
        check("rst lsu_ready", lsu_ready, 0);
        @(negedge CLK);
        @(negedge CLK);
        idle_inputs();
        reset_n = 1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge CLK);
            v = vq[i];
            alu_valid = v.av; alu_rd = v.ard; alu_data = v.adat;
            lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ldat;
            issue_valid = v.iv; issue_rd = v.ird; flush = v.fl;
            A1 = v.a1; A2 = v.a2;
            #1;
            check($sformatf("v%0d alu_ready", i), alu_ready, v.ar);
            check($sformatf("v%0d lsu_ready", i), lsu_ready, v.lr);
            check($sformatf("v%0d stall", i), stall, FWD ? v.stf : v.st);
            check($sformatf("v%0d WE", i), WE, v.we);
            check($sformatf("v%0d A3", i), A3, v.a3);
            check($sformatf("v%0d WD3", i), WD3, v.wd);
        end

        // Asynchronous reset while a write is on the port and a register is busy
        @(negedge CLK);
        idle_inputs();
        alu_valid = 1; alu_rd = 12; alu_data = 32'h00C0FFEE;
        issue_valid = 1; issue_rd = 13; A1 = 13;
        #1;
        check("mid alu_ready", alu_ready, 1);
        @(negedge CLK);
        idle_inputs();
        A1 = 13;
        #1;
        check("mid WE", WE, 1);
        check("mid A3", A3, 12);
        check("mid WD3", WD3, 32'h00C0FFEE);
        check("mid stall", stall, 1);
        #1;
        reset_n = 0;
        #1;
        check("async WE", WE, 0);
        check("async A3", A3, 0);
        check("async WD3", WD3, 0);
        check("async stall", stall, 0);
        alu_valid = 1; alu_rd = 4;
        #1;
        check("async alu_ready", alu_ready, 0);
        @(negedge CLK);
        idle_inputs();
        reset_n = 1;
        for (int r = 1; r < 32; r++) begin
            A1 = 5'(r); A2 = 5'(r);
            #1;
            check($sformatf("post-rst stall x%0d", r), stall, 0);
        end
        alu_valid = 1; alu_rd = 1; lsu_valid = 1; lsu_rd = 2; A1 = 0; A2 = 0;
        #1;
        check("post-rst alu_ready", alu_ready, 1);
        check("post-rst lsu_ready", lsu_ready, 0);
        @(negedge CLK);
        idle_inputs();
        @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
